// File: rtl/fifo_async_gtob_sync.sv
// Read-side receiver for an asynchronous FIFO write pointer.
// Brings the foreign-domain Gray write pointer into the local clock domain
// through a plain flop chain and converts it back to binary. It then derives
// empty/level against the local binary read pointer. Two sticky flags record
// Gray coding violations and fill levels beyond the FIFO depth.
module fifo_async_gtob_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wptr_gray_async,
    input  logic [WIDTH-1:0] rptr_bin,
    input  logic             err_clr,
    output logic [WIDTH-1:0] wptr_bin,
    output logic             empty,
    output logic [WIDTH-1:0] level,
    output logic             gray_err,
    output logic             ovf_err
);

    // FIFO depth is half the pointer space; the top bit is the wrap bit.
    localparam logic [WIDTH-1:0] DEPTH = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    // Index 0 is the first flop to see the asynchronous input and
    // index SYNC_STAGES-1 is the synchronized output.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_out;
    logic [WIDTH-1:0]                  gray_prev_q;
    logic [WIDTH-1:0]                  wptr_bin_q;
    logic [WIDTH-1:0]                  wptr_bin_d;
    logic [WIDTH-1:0]                  gray_diff;
    logic [WIDTH-1:0]                  level_raw;
    logic                              gray_bad;
    logic                              ovf_bad;
    logic                              gray_err_q;
    logic                              gray_err_d;
    logic                              ovf_err_q;
    logic                              ovf_err_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // This is written as a reduction per bit so that no bit depends on another.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_gtob
            assign wptr_bin_d[gi] = ^sync_out[WIDTH-1:gi];
        end
    endgenerate

    // More than one differing bit: clearing the lowest set bit leaves something.
    assign gray_diff = sync_out ^ gray_prev_q;
    assign gray_bad  = (gray_diff & (gray_diff - ONE)) != '0;

    // Modulo subtraction handles pointer wrap without a special case.
    assign level_raw = wptr_bin_q - rptr_bin;
    assign ovf_bad   = level_raw > DEPTH;

    // Set has priority over clear so that a persisting fault is never lost.
    assign gray_err_d = gray_bad | (gray_err_q & ~err_clr);
    assign ovf_err_d  = ovf_bad  | (ovf_err_q  & ~err_clr);

    // Synchronizer chain. No logic is allowed between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray_async};
        end
    end

    // Previous-value register and registered binary write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_prev_q <= '0;
            wptr_bin_q  <= '0;
        end else begin
            gray_prev_q <= sync_out;
            wptr_bin_q  <= wptr_bin_d;
        end
    end

    // Sticky integrity flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            gray_err_q <= gray_err_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    // While reset is held, report an empty FIFO whatever the read pointer says.
    assign wptr_bin = wptr_bin_q;
    assign empty    = rst ? 1'b1 : (wptr_bin_q == rptr_bin);
    assign level    = rst ? '0   : level_raw;
    assign gray_err = gray_err_q;
    assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_fifo_async_gtob_sync.sv
// Directed bench for fifo_async_gtob_sync at WIDTH=4, SYNC_STAGES=2.
module tb_fifo_async_gtob_sync;

    logic       clk;
    logic       rst;
    logic [3:0] wptr_gray_async;
    logic [3:0] rptr_bin;
    logic       err_clr;
    logic [3:0] wptr_bin;
    logic       empty;
    logic [3:0] level;
    logic       gray_err;
    logic       ovf_err;

    int total;
    int bad;

    fifo_async_gtob_sync #(
        .WIDTH      (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wptr_gray_async(wptr_gray_async),
        .rptr_bin       (rptr_bin),
        .err_clr        (err_clr),
        .wptr_bin       (wptr_bin),
        .empty          (empty),
        .level          (level),
        .gray_err       (gray_err),
        .ovf_err        (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] gray;
        logic [3:0] rptr;
        logic       clr;
        int         ticks;
        logic [3:0] exp_wptr;
        logic       exp_empty;
        logic [3:0] exp_level;
        logic       exp_gerr;
        logic       exp_oerr;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] w, input logic e,
                           input logic [3:0] l, input logic ge, input logic oe);
        chk({name, ".wptr"}, 16'(wptr_bin), 16'(w));
        chk({name, ".empty"}, 16'(empty), 16'(e));
        chk({name, ".level"}, 16'(level), 16'(l));
        chk({name, ".gray_err"}, 16'(gray_err), 16'(ge));
        chk({name, ".ovf_err"}, 16'(ovf_err), 16'(oe));
        $display("vec %s: wptr=%0d empty=%0b level=%0d gerr=%0b oerr=%0b",
                 name, wptr_bin, empty, level, gray_err, ovf_err);
    endtask

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        //            name        gray     rptr  clr tk  wptr e  lvl ge oe
        vecs[0]  = '{"lat_2edge", 4'b0001, 4'd0, 0, 2, 4'd0, 1, 4'd0, 0, 0};
        vecs[1]  = '{"lat_3edge", 4'b0001, 4'd0, 0, 1, 4'd1, 0, 4'd1, 0, 0};
        vecs[2]  = '{"rd_catch",  4'b0001, 4'd1, 0, 0, 4'd1, 1, 4'd0, 0, 0};
        vecs[3]  = '{"gviol_2",   4'b0010, 4'd1, 0, 2, 4'd1, 1, 4'd0, 0, 0};
        vecs[4]  = '{"gviol_3",   4'b0010, 4'd1, 0, 1, 4'd3, 0, 4'd2, 1, 0};
        vecs[5]  = '{"gclr",      4'b0010, 4'd1, 1, 1, 4'd3, 0, 4'd2, 0, 0};
        vecs[6]  = '{"ovf_lvl",   4'b1101, 4'd0, 0, 3, 4'd9, 0, 4'd9, 1, 0};
        vecs[7]  = '{"ovf_set",   4'b1101, 4'd0, 0, 1, 4'd9, 0, 4'd9, 1, 1};
        vecs[8]  = '{"ovf_hold",  4'b1101, 4'd0, 1, 1, 4'd9, 0, 4'd9, 0, 1};
        vecs[9]  = '{"ovf_clr",   4'b1101, 4'd5, 1, 1, 4'd9, 0, 4'd4, 0, 0};
        vecs[10] = '{"lvl_eq_8",  4'b1101, 4'd1, 0, 1, 4'd9, 0, 4'd8, 0, 0};
        vecs[11] = '{"lvl_9_now", 4'b1101, 4'd0, 0, 0, 4'd9, 0, 4'd9, 0, 0};
        vecs[12] = '{"lvl_9_set", 4'b1101, 4'd0, 0, 1, 4'd9, 0, 4'd9, 0, 1};
        vecs[13] = '{"ovf_clr2",  4'b1101, 4'd2, 1, 1, 4'd9, 0, 4'd7, 0, 0};

        // Reset with a nonzero read pointer.
        rst             = 1'b1;
        wptr_gray_async = 4'b0000;
        rptr_bin        = 4'd5;
        err_clr         = 1'b0;
        tick();
        tick();
        chk_all("reset", 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);

        rptr_bin = 4'd0;
        rst      = 1'b0;
        tick();
        chk_all("post_reset", 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);

        // Table-driven latency, Gray violation and overflow vectors.
        for (int i = 0; i < 14; i++) begin
            wptr_gray_async = vecs[i].gray;
            rptr_bin        = vecs[i].rptr;
            err_clr         = vecs[i].clr;
            for (int k = 0; k < vecs[i].ticks; k++) begin
                tick();
                err_clr = 1'b0;
            end
            err_clr = 1'b0;
            #1;
            chk_all(vecs[i].name, vecs[i].exp_wptr, vecs[i].exp_empty,
                    vecs[i].exp_level, vecs[i].exp_gerr, vecs[i].exp_oerr);
        end

        // Wrap-around walk with the read pointer lagging by three.
        rst = 1'b1;
        wptr_gray_async = 4'b0000;
        #2;
        rst = 1'b0;
        rptr_bin = 4'd13;
        tick();
        chk_all("wrap_start", 4'd0, 1'b0, 4'd3, 1'b0, 1'b0);
        for (int b = 1; b <= 16; b++) begin
            logic [3:0] bv;
            bv = 4'(b);
            wptr_gray_async = b2g(bv);
            tick();
            tick();
            tick();
            rptr_bin = bv - 4'd3;
            #1;
            chk_all($sformatf("wrap_%0d", b), bv, 1'b0, 4'd3, 1'b0, 1'b0);
        end

        // Reset in the middle of a stream.
        wptr_gray_async = b2g(4'd7);
        rptr_bin = 4'd0;
        tick();
        tick();
        tick();
        chk_all("pre_rst", 4'd7, 1'b0, 4'd7, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("mid_rst_async", 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        chk_all("mid_rst_held", 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        chk_all("rel_2edge", 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        chk_all("rel_3edge", 4'd7, 1'b0, 4'd7, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Whole-run safety net so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
